// File: rtl/rm_report_pkg.sv
// Shared defaults and record layout for the automata-cluster report collector.
package rm_report_pkg;

  localparam int NUM_RPT_DEF  = 3;
  localparam int OFFSET_W_DEF = 32;

  typedef struct packed {
    logic [OFFSET_W_DEF-1:0] offset;
    logic [NUM_RPT_DEF-1:0]  mask;
  } rpt_rec_t;

endpackage

// File: rtl/rm_report_fifo.sv
// Pointer-based record FIFO with wrap-bit full/empty detection.
// Latency: write visible on the read port the cycle after it is accepted.
// Backpressure: writes refused when full unless a read completes in the same cycle.
module rm_report_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  output logic             empty,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_vld = ~empty;
  assign rd_en  = rd_vld & rd_rdy;
  // A pop frees the slot the incoming record lands in, so full+pop still accepts.
  assign wr_en  = wr_vld & (~full | rd_en);
  assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/rm_report_collector.sv
// Tags cluster match reports with their symbol offset and queues them as records.
// Latency: record visible one cycle after the report; overflowing reports are dropped and counted.
// Backpressure: rec_ready stalls the head; a full FIFO without a pop drops the new record.
module rm_report_collector
  import rm_report_pkg::*;
#(
  parameter int NUM_RPT  = NUM_RPT_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                clear,
  input  logic [NUM_RPT-1:0]  report,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [OFFSET_W-1:0] rec_offset,
  output logic [NUM_RPT-1:0]  rec_mask,
  output logic                overflow,
  output logic [15:0]         drop_cnt,
  output logic [OFFSET_W-1:0] sym_cnt
);

  typedef struct packed {
    logic [OFFSET_W-1:0] offset;
    logic [NUM_RPT-1:0]  mask;
  } rec_t;

  logic                run_q;
  logic [OFFSET_W-1:0] off_q;
  logic                push_vld;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;
  rec_t                wr_dat;
  rec_t                rd_dat;

  // Reports describe the symbol accepted one cycle earlier, hence the staged run/offset.
  assign push_vld = run_q & (|report);
  assign drop     = push_vld & fifo_full & ~(~fifo_empty & rec_ready);
  assign wr_dat   = '{offset: off_q, mask: report};

  rm_report_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .wr_vld (push_vld),
    .wr_dat (wr_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .rd_vld (rec_valid),
    .rd_rdy (rec_ready),
    .rd_dat (rd_dat)
  );

  assign rec_offset = rd_dat.offset;
  assign rec_mask   = rd_dat.mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      off_q    <= '0;
      sym_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      run_q    <= 1'b0;
      off_q    <= '0;
      sym_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      run_q <= run;
      off_q <= sym_cnt;
      if (run) sym_cnt <= sym_cnt + OFFSET_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/rm_report_collector.md
RM_REPORT_COLLECTOR -- requirements
Module: rm_report_collector

Interface
REQ-001 Parameter NUM_RPT, default 3: number of per-property report lines from one automata cluster (ltl0..ltl2).
REQ-002 Parameter OFFSET_W, default 32: width of the symbol offset counter.
REQ-003 Parameter DEPTH, default 8: record FIFO depth, power of two, minimum 2.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  symbol-accept strobe, same signal that drives the cluster; one symbol consumed per high cycle.
REQ-007 clear  in  1  synchronous flush: FIFO, counters and overflow flag.
REQ-008 report  in  NUM_RPT  cluster match lines; bit i = ltl<i>; relate to the symbol accepted in the previous cycle.
REQ-009 rec_valid  out  1  head record available.
REQ-010 rec_ready  in  1  consumer accepts the head record.
REQ-011 rec_offset  out  OFFSET_W  offset of the symbol that produced the head record.
REQ-012 rec_mask  out  NUM_RPT  report bits of the head record.
REQ-013 overflow  out  1  sticky: at least one record dropped.
REQ-014 drop_cnt  out  16  dropped-record count, saturating.
REQ-015 sym_cnt  out  OFFSET_W  count of symbols accepted since reset/clear.

Function
REQ-016 sym_cnt SHALL increment by 1 on each cycle with run=1; it wraps modulo 2^OFFSET_W.
REQ-017 A stage register SHALL capture run into run_q and sym_cnt into off_q each cycle.
REQ-018 A push SHALL occur in the cycle where run_q=1 and report is nonzero; the record is {off_q, report}.
REQ-019 report while run_q=0 SHALL be ignored.
REQ-020 A pop SHALL occur when rec_valid=1 and rec_ready=1; the next record appears the following cycle.
REQ-021 rec_valid SHALL be high exactly when the FIFO is non-empty; rec_offset and rec_mask SHALL stay stable while rec_valid=1 and rec_ready=0.
REQ-022 Push-to-visible latency SHALL be 1 cycle: rec_valid asserts in the cycle after the push into an empty FIFO.
REQ-023 Full and push without pop: the record SHALL be dropped, overflow set, and drop_cnt incremented, saturating at 16'hFFFF.
REQ-024 Full and push with pop in the same cycle: both SHALL complete, with no drop and occupancy unchanged.
REQ-025 Empty and push with rec_ready=1: no bypass; the record SHALL appear the next cycle.
REQ-026 Read and write pointers SHALL be log2(DEPTH)+1 bits with wrap bit; full means equal indices and differing wrap bits.
REQ-027 clear SHALL take priority over push and pop in the same cycle: empty FIFO, sym_cnt=0, run_q=0, overflow=0, drop_cnt=0.
REQ-028 Record ordering SHALL be strictly FIFO, with no coalescing of records.

Reset
REQ-029 On reset low, the following SHALL be forced immediately: rec_valid=0, rec_offset=0, rec_mask=0, overflow=0, drop_cnt=0, sym_cnt=0, run_q=0, off_q=0, pointers=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored records; the first run after release counts as offset 0.
REQ-031 FIFO storage array need not be reset; its outputs SHALL be masked by rec_valid=0.

Structure
REQ-032 Package rm_report_pkg SHALL hold the NUM_RPT and OFFSET_W defaults and the record typedef {offset, mask}.
REQ-033 Storage SHALL be a sub-module rm_report_fifo: parameterized DEPTH, valid/ready read port, full/empty flags.
REQ-034 The top SHALL hold the counters, the stage register, the drop logic and the overflow logic.

Verification
REQ-035 Scenario 1: run=1 for 5 cycles; report=3'b010 in the cycle after the third symbol -> one record, offset=2, mask=010, rec_valid one cycle later.
REQ-036 Scenario 2: rec_ready=0, DEPTH=8, 10 reporting symbols -> 8 records held, overflow=1, drop_cnt=2; then drain yields offsets in order.
REQ-037 Scenario 3: FIFO full, push and pop in the same cycle -> drop_cnt unchanged, occupancy stays 8.
REQ-038 Scenario 4: preload sym_cnt near 2^OFFSET_W-1 (OFFSET_W=4 build), 18 runs with reports -> offsets wrap 15 to 0 correctly.
REQ-039 Scenario 5: reset pulsed low mid-burst with 3 records queued -> rec_valid=0 asynchronously; after release the first record has offset 0.
REQ-040 Scenario 6: clear together with push and pop -> FIFO empty, counters 0, no record from that cycle retained.
